seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked RV32IM/RV64IM-style execute unit that generalises the combinational integer ALU. It adds RISC-V M-extension multiply and divide, implemented as iterative multi-cycle datapaths behind a valid/ready interface. All results are registered. It sits in the execute stage between operand fetch and writeback, and replaces the single-cycle ALU wherever stalls are tolerable.

## Interface
- XLEN, 32, operand/result width; power of two, 8..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; in_ready = (state==IDLE) || (state==DONE && out_ready).
- op  in  5  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18..31 reserved.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm); shift amount = b[$clog2(XLEN)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- busy  out  1  high in MUL or DIV state.

## Operation
- Accept when in_valid && in_ready at a rising edge. op, a and b are captured; later input changes are ignored.
- States:
  - IDLE: waits for an accept.
  - ALU class (ops 0..9, reserved): result is computed and registered at the accept edge; go to DONE.
  - MUL class (10..13): go to MUL. Shift-add over XLEN+1-bit sign/zero-extended operands, 2·XLEN-bit product register, one bit per cycle, XLEN iterations, then DONE.
  - DIV class (14..17): if divisor is zero or the op is signed overflow, go straight to DONE with the fixed result. Otherwise go to DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN iterations, sign fix-up in the final iteration, then DONE.
  - DONE: out_valid=1; result and zero are held stable. If out_ready, leave DONE. Go to IDLE, or start the next op directly if in_valid is also high at that edge.
- Arithmetic (mod 2^XLEN):
  - SUB = a-b.
  - SRA sign-fills.
  - SLT signed and SLTU unsigned both return 0 or 1.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits of signed×signed, signed×unsigned and unsigned×unsigned.
  - DIV/REM truncate toward zero; the remainder sign follows the dividend.
- Special cases (RISC-V):
  - x/0: DIV and DIVU return all-ones; REM and REMU return a.
  - DIV of -2^(XLEN-1) by -1 returns -2^(XLEN-1); REM returns 0.
- Reserved opcodes: result 0, zero=1, latency 1.

## Timing
- Reset values: out_valid=0, result=0, zero=0, busy=0, state=IDLE. in_ready=1 in the cycle after reset is released.
- Latency, counted from the accept edge to the edge after which out_valid=1:
  - ALU, reserved, div-by-zero and overflow: 1.
  - MUL and DIV: XLEN+1 (33 at XLEN=32).
- Throughput: with out_ready held at 1, one ALU op per cycle. The iterative classes are not pipelined; in_ready=0 while busy.
- If out_ready=0 in DONE, the unit holds the result indefinitely; nothing is dropped and nothing is overwritten.
- rst during MUL, DIV or DONE aborts the operation at that edge and applies the reset values above; the partial result is discarded.
- The iteration counter is $clog2(XLEN)+1 bits, clears on accept and never wraps during an operation.

## Test plan
- Reset, then ADD 10+5 → result 15, zero=0, one cycle after accept. SUB 10-10 → 0, zero=1. SRA 0x8000000F by 2 → 0xE0000003. SLT -10,5 → 1. SLTU 10,5 → 0.
- a=b=0xFFFFFFFF:
  - MUL → 0x00000001.
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - Each has out_valid exactly 33 cycles after accept, with busy high for 32 of them.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF with latency 1; REMU 7/0 → 7; DIV 0x80000000/-1 → 0x80000000 and REM → 0, both with latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result → result and out_valid stable, in_ready=0. Then out_ready=1 with a pending in_valid → the new op is accepted the same edge, and the next result follows one cycle later.
- Assert rst at iteration 10 of a DIVU → next cycle out_valid=0, busy=0, result=0, in_ready=1. A following ADD 1+1 returns 2.
- Reserved op 20 with a=5, b=3 → result 0, zero=1, latency 1.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked RV32IM/RV64IM-style execute unit: single-cycle ALU ops plus iterative
// shift-add multiply and restoring divide, all results registered behind valid/ready.
module seq_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned CW = SW + 1;
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1,  OpAnd = 5'd2,  OpOr = 5'd3;
    localparam logic [4:0] OpXor = 5'd4,  OpSll = 5'd5,  OpSrl = 5'd6,  OpSra = 5'd7;
    localparam logic [4:0] OpSlt = 5'd8,  OpSltu = 5'd9, OpMul = 5'd10, OpMulh = 5'd11;
    localparam logic [4:0] OpMulhsu = 5'd12, OpMulhu = 5'd13, OpDiv = 5'd14, OpDivu = 5'd15;
    localparam logic [4:0] OpRem = 5'd16, OpRemu = 5'd17;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d, start_state;
    logic              accept, last;
    logic [CW-1:0]     cnt_q;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;

    logic              is_mul, is_div, is_rem, div_signed, div_special;
    logic [XLEN-1:0]   alu_res, div_fixed, a_mag, b_mag, start_res;

    logic [2*XLEN-1:0] prod_q, mcand_q, addend, prod_nxt;
    logic [XLEN-1:0]   mplier_q, mul_res;
    logic              bneg_q;

    logic [XLEN-1:0]   rem_q, quo_q, dvs_q, rem_nxt, quo_nxt, div_res;
    logic [XLEN:0]     shifted, diff;
    logic              qneg_q, rneg_q;

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == CW'(XLEN - 1));

    // Decode of the incoming request
    always_comb begin
        is_mul      = (op >= OpMul) && (op <= OpMulhu);
        is_div      = (op >= OpDiv) && (op <= OpRemu);
        is_rem      = (op == OpRem) || (op == OpRemu);
        div_signed  = (op == OpDiv) || (op == OpRem);
        a_mag       = (div_signed && a[XLEN-1]) ? -a : a;
        b_mag       = (div_signed && b[XLEN-1]) ? -b : b;
        div_special = 1'b0;
        div_fixed   = '0;
        if (b == '0) begin
            div_special = 1'b1;
            div_fixed   = is_rem ? a : '1;
        end else if (div_signed && (a == MinInt) && (b == '1)) begin
            div_special = 1'b1;
            div_fixed   = is_rem ? '0 : MinInt;
        end
        start_res = is_div ? div_fixed : alu_res;
        if (is_mul) begin
            start_state = StMul;
        end else if (is_div && !div_special) begin
            start_state = StDiv;
        end else begin
            start_state = StDone;
        end
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpSll:   alu_res = a << b[SW-1:0];
            OpSrl:   alu_res = a >> b[SW-1:0];
            OpSra:   alu_res = $signed(a) >>> b[SW-1:0];
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, a < b};
            default: alu_res = '0;
        endcase
    end

    // Multiplier msb carries negative weight for signed x signed.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        prod_nxt = (last && bneg_q) ? prod_q - addend : prod_q + addend;
        mul_res  = (op_q == OpMul) ? prod_nxt[XLEN-1:0] : prod_nxt[2*XLEN-1:XLEN];
    end

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
        if ((op_q == OpRem) || (op_q == OpRemu)) begin
            div_res = rneg_q ? -rem_nxt : rem_nxt;
        end else begin
            div_res = qneg_q ? -quo_nxt : quo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = start_state;
            StMul:   if (last) state_d = StDone;
            StDiv:   if (last) state_d = StDone;
            StDone: begin
                if (accept) begin
                    state_d = start_state;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        busy      = (state_q == StMul) || (state_q == StDiv);
        result    = result_q;
        zero      = zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bneg_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= op;
            prod_q   <= '0;
            mcand_q  <= ((op == OpMulh) || (op == OpMulhsu)) ?
                        {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
            mplier_q <= b;
            bneg_q   <= (op == OpMulh);
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvs_q    <= b_mag;
            qneg_q   <= div_signed && (a[XLEN-1] ^ b[XLEN-1]);
            rneg_q   <= div_signed && a[XLEN-1];
            if (start_state == StDone) begin
                result_q <= start_res;
                zero_q   <= (start_res == '0);
            end
        end else if (state_q == StMul) begin
            cnt_q    <= cnt_q + CW'(1);
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (last) begin
                result_q <= mul_res;
                zero_q   <= (mul_res == '0);
            end
        end else if (state_q == StDiv) begin
            cnt_q <= cnt_q + CW'(1);
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (last) begin
                result_q <= div_res;
                zero_q   <= (div_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at XLEN=32, plus backpressure, throughput
// and mid-operation reset sequences.
module tb_seq_alu;

    localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1,  OpAnd = 5'd2,  OpOr = 5'd3;
    localparam logic [4:0] OpXor = 5'd4,  OpSll = 5'd5,  OpSrl = 5'd6,  OpSra = 5'd7;
    localparam logic [4:0] OpSlt = 5'd8,  OpSltu = 5'd9, OpMul = 5'd10, OpMulh = 5'd11;
    localparam logic [4:0] OpMulhsu = 5'd12, OpMulhu = 5'd13, OpDiv = 5'd14, OpDivu = 5'd15;
    localparam logic [4:0] OpRem = 5'd16, OpRemu = 5'd17;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input int lat);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issues one op from idle, waits (bounded) for the result, checks it, then consumes it.
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r, input int lat);
        int n;
        int bc;
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; op = OpAdd; a = ~x; b = ~y;
        n = 1;
        bc = busy ? 1 : 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
            if (busy) bc++;
        end
        check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, " result"}, result, r);
        check({name, " zero"}, {31'd0, zero}, {31'd0, r == 32'd0});
        check({name, " latency"}, n, lat);
        check({name, " busy cycles"}, bc, lat - 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        add_vec(OpAdd,    32'd10,        32'd5,         32'd15,        1);
        add_vec(OpSub,    32'd10,        32'd10,        32'd0,         1);
        add_vec(OpSra,    32'h8000000F,  32'd2,         32'hE0000003,  1);
        add_vec(OpSlt,    32'hFFFFFFF6,  32'd5,         32'd1,         1);
        add_vec(OpSltu,   32'd10,        32'd5,         32'd0,         1);
        add_vec(OpAnd,    32'h0000F0F0,  32'h0000FF00,  32'h0000F000,  1);
        add_vec(OpOr,     32'h0000F0F0,  32'h0000FF00,  32'h0000FFF0,  1);
        add_vec(OpXor,    32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  1);
        add_vec(OpSll,    32'd1,         32'd31,        32'h80000000,  1);
        add_vec(OpSll,    32'd1,         32'h21,        32'd2,         1);
        add_vec(OpSrl,    32'h80000000,  32'd31,        32'd1,         1);
        add_vec(OpAdd,    32'hFFFFFFFF,  32'd1,         32'd0,         1);
        add_vec(OpMul,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  33);
        add_vec(OpMulh,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  33);
        add_vec(OpMulhu,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33);
        add_vec(OpMulhsu, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  33);
        add_vec(OpMul,    32'h12345678,  32'h10,        32'h23456780,  33);
        add_vec(OpMulh,   32'h80000000,  32'h80000000,  32'h40000000,  33);
        add_vec(OpDiv,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33);
        add_vec(OpRem,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33);
        add_vec(OpDiv,    32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33);
        add_vec(OpRem,    32'd7,         32'hFFFFFFFE,  32'd1,         33);
        add_vec(OpDivu,   32'd100,       32'd7,         32'd14,        33);
        add_vec(OpRemu,   32'd100,       32'd7,         32'd2,         33);
        add_vec(OpDivu,   32'd7,         32'd0,         32'hFFFFFFFF,  1);
        add_vec(OpRemu,   32'd7,         32'd0,         32'd7,         1);
        add_vec(OpDiv,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1);
        add_vec(OpRem,    32'h80000000,  32'hFFFFFFFF,  32'd0,         1);
        add_vec(5'd20,    32'd5,         32'd3,         32'd0,         1);

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].lat);
        end

        // Backpressure: result held while out_ready=0, pending request waits.
        op = OpAdd; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        op = OpXor; a = 32'hF; b = 32'h3;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d result", k), result, 32'd7);
            check($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp next out_valid", {31'd0, out_valid}, 32'd1);
        check("bp next result", result, 32'h0000000C);
        // Back-to-back ALU ops at full rate.
        op = OpSub; a = 32'd10; b = 32'd3;
        tick();
        check("thru result", result, 32'd7);
        check("thru in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("thru drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset during the tenth divide iteration.
        op = OpDivu; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("abort busy before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        run_op("post-abort add", OpAdd, 32'd1, 32'd1, 32'd2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
